instr_encoder: RTL and testbench

//  Encoder counterpart of the core's instruction decoder: accepts mnemonic+field descriptors over a

---
 rtl/instr_encoder.sv | 108 ++++++++++
 tb/tb_instr_encoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs mnemonic/field descriptors into 32-bit MIPS words and streams them into
// consecutive instruction-memory words, one per cycle, with a saturating fill pointer.
module instr_encoder #(
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] BASE_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [31:0]       im_pc,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    // state  | meaning
    // S_IDLE | after reset, waiting for start; inputs ignored
    // S_RUN  | accepting descriptors while space remains
    // S_FULL | DEPTH words written; inputs ignored until start
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

    localparam logic [ADDR_W+1:0] DEPTH = {1'b0, 1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LAST  = {1'b0, {ADDR_W{1'b1}}};

    state_t            state, state_nxt;
    logic [ADDR_W+1:0] occupancy;
    logic              accept;
    logic              legal;
    logic [31:0]       enc_word;

    // im_we doubles as the "write pending" flag: it reserves a slot not yet in count
    assign occupancy = {1'b0, count} + {{(ADDR_W+1){1'b0}}, im_we};
    assign in_ready  = (state == S_RUN) && (occupancy < DEPTH) && !start;
    assign accept    = in_valid && in_ready;
    assign legal     = (mnem <= 4'd11);
    assign full      = (state == S_FULL);
    assign im_pc     = BASE_PC + (32'(im_addr) << 2);

    always_comb begin
        enc_word = 32'h0;
        case (mnem)
            4'd0:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd1:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            4'd2:    enc_word = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
            4'd3:    enc_word = {6'h00, rs, 15'd0, 6'h08};
            4'd4:    enc_word = {6'h23, rs, rt, imm};
            4'd5:    enc_word = {6'h2B, rs, rt, imm};
            4'd6:    enc_word = {6'h0D, rs, rt, imm};
            4'd7:    enc_word = {6'h0F, 5'd0, rt, imm};
            4'd8:    enc_word = {6'h04, rs, rt, imm};
            4'd9:    enc_word = {6'h02, target};
            4'd10:   enc_word = {6'h03, target};
            default: enc_word = 32'h0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_RUN;
        end else if (state == S_RUN && im_we && count == LAST) begin
            state_nxt = S_FULL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'h0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            im_we <= accept && legal;
            // address is taken at accept time so a pending write keeps its slot across start
            if (accept && legal) begin
                im_wdata <= enc_word;
                im_addr  <= count[ADDR_W-1:0] + ADDR_W'(im_we);
            end
            if (start) begin
                count <= '0;
                err   <= 1'b0;
            end else begin
                if (im_we) begin
                    count <= count + 1'b1;
                end
                if (accept && !legal) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver predicts writes from an arithmetic
// encoding model, monitor pops and checks each im_we beat.
module tb_instr_encoder;

    localparam int          AW    = 3;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_ready;
    logic [3:0]    mnem;
    logic [4:0]    rs, rt, rd, shamt;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata, im_pc;
    logic [AW:0]   count;
    logic          full, err;

    instr_encoder #(.ADDR_W(AW), .BASE_PC(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_pc(im_pc),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          addr;
        logic [31:0] word;
        int          acc_cyc;
    } exp_t;
    exp_t sb[$];

    bit          run_m, full_m, err_m, pend_m;
    int          legal_acc;
    logic [31:0] last_w;
    int          last_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_encode(input int m, input logic [31:0] s, input logic [31:0] t,
                                               input logic [31:0] d, input logic [31:0] sh,
                                               input logic [31:0] im, input logic [31:0] tg);
        logic [31:0] r;
        case (m)
            0:  r = (s << 21) | (t << 16) | (d << 11) | 32'h20;
            1:  r = (s << 21) | (t << 16) | (d << 11) | 32'h22;
            2:  r = (t << 16) | (d << 11) | (sh << 6);
            3:  r = (s << 21) | 32'h08;
            4:  r = (32'h23 << 26) | (s << 21) | (t << 16) | im;
            5:  r = (32'h2B << 26) | (s << 21) | (t << 16) | im;
            6:  r = (32'h0D << 26) | (s << 21) | (t << 16) | im;
            7:  r = (32'h0F << 26) | (t << 16) | im;
            8:  r = (32'h04 << 26) | (s << 21) | (t << 16) | im;
            9:  r = (32'h02 << 26) | tg;
            10: r = (32'h03 << 26) | tg;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (im_we) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %h expected no write", im_addr, im_wdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("im_addr", 32'(im_addr), e.addr);
                    chk("im_wdata", im_wdata, e.word);
                    chk("im_pc", im_pc, BASE + 32'(4 * e.addr));
                    chk("latency", cyc, e.acc_cyc + 1);
                    last_w = e.word;
                    last_a = e.addr;
                end
            end else begin
                chk("hold_wdata", im_wdata, last_w);
                chk("hold_addr", 32'(im_addr), last_a);
            end
        end
    end

    // one clock: check status against the model, predict acceptance, advance the model
    task automatic step(output bit acc);
        bit exp_ready, lg;
        @(negedge clk);
        exp_ready = run_m && !start && (legal_acc < DEPTH);
        chk("in_ready", in_ready, exp_ready);
        chk("count", 32'(count), legal_acc - int'(pend_m));
        chk("full", full, full_m);
        chk("err", err, err_m);
        acc = in_valid && exp_ready;
        if (start) begin
            run_m = 1; full_m = 0; err_m = 0; pend_m = 0; legal_acc = 0;
        end else begin
            lg = (mnem < 4'd12);
            if (acc && lg) begin
                exp_t e;
                e.addr    = legal_acc;
                e.word    = ref_encode(int'(mnem), 32'(rs), 32'(rt), 32'(rd), 32'(shamt), 32'(imm), 32'(target));
                e.acc_cyc = cyc;
                sb.push_back(e);
                legal_acc++;
            end
            if (acc && !lg) err_m = 1;
            pend_m = acc && lg;
            if (run_m && legal_acc - int'(pend_m) == DEPTH) begin
                full_m = 1;
                run_m  = 0;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1; start = 0; in_valid = 0;
        #1;
        chk("rst_im_we", im_we, 1'b0);
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_im_addr", 32'(im_addr), 0);
        chk("rst_im_wdata", im_wdata, 32'h0);
        chk("rst_im_pc", im_pc, BASE);
        sb.delete();
        run_m = 0; full_m = 0; err_m = 0; pend_m = 0; legal_acc = 0;
        last_w = 32'h0; last_a = 0;
        @(posedge clk);
        #2;
        reset = 0;
    endtask

    task automatic send(input int m, input int s, input int t, input int d, input int sh,
                        input int im, input int tg);
        bit acc;
        mnem = 4'(m); rs = 5'(s); rt = 5'(t); rd = 5'(d); shamt = 5'(sh);
        imm = 16'(im); target = 26'(tg);
        in_valid = 1;
        acc = 0;
        for (int i = 0; i < 20 && !acc; i++) step(acc);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
        in_valid = 0;
    endtask

    task automatic pulse_start();
        bit acc;
        start = 1;
        step(acc);
        start = 0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        bit acc;
        reset = 1; start = 0; in_valid = 0;
        mnem = 0; rs = 0; rt = 0; rd = 0; shamt = 0; imm = 0; target = 0;
        do_reset();
        idle(2);

        // basic add
        pulse_start();
        send(0, 1, 2, 3, 7, 16'hBEEF, 0);
        idle(2);

        // back-to-back mixed stream
        pulse_start();
        send(6, 0, 1, 0, 0, 16'h1234, 0);
        send(7, 9, 2, 0, 0, 16'hFFFF, 0);
        send(2, 3, 5, 4, 2, 0, 0);
        send(8, 1, 2, 0, 0, 16'hFFFF, 0);
        send(3, 31, 4, 5, 6, 0, 0);
        send(10, 0, 0, 0, 0, 0, 26'h0C00);
        idle(2);

        // fill to DEPTH, then hold a descriptor that must not be taken
        pulse_start();
        for (int i = 0; i < DEPTH; i++) send(11, i, i, i, i, i, i);
        mnem = 0; rs = 1; rt = 2; rd = 3; in_valid = 1;
        idle(4);
        in_valid = 0;
        idle(1);

        // illegal mnemonic then add; start clears err
        pulse_start();
        send(13, 1, 2, 3, 0, 0, 0);
        send(0, 4, 5, 6, 0, 0, 0);
        idle(2);
        pulse_start();
        idle(1);

        // start coincident with a valid descriptor drops it
        mnem = 1; rs = 7; rt = 8; rd = 9; in_valid = 1;
        pulse_start();
        in_valid = 0;
        send(1, 10, 11, 12, 0, 0, 0);
        idle(2);

        // start while a write is pending
        send(4, 1, 2, 0, 0, 16'h0040, 0);
        start = 1;
        step(acc);
        start = 0;
        send(5, 3, 4, 0, 0, 16'h0080, 0);
        idle(2);

        // reset during the write cycle aborts it
        pulse_start();
        send(0, 1, 1, 1, 0, 0, 0);
        do_reset();
        idle(3);

        // randomized traffic
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mnem = 4'($urandom_range(12, 15));
            else                           mnem = 4'($urandom_range(0, 11));
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
            imm = 16'($urandom); target = 26'($urandom);
            step(acc);
        end
        start = 0; in_valid = 0;
        idle(3);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
